// File: rtl/ha_array_acc_seq.sv
// ha_array_acc_seq: sequencing controller for the 8x8 approximate multiplier's
// half-adder compression stage. It accepts an operand pair, drives it onto the
// external combinational ha_array datapath, and folds the four weighted row
// outputs into a 16-bit product using one shared adder. The adder handles
// ROWS_PER_CYCLE rows per cycle.
// Build option: define HA_ACC_SAT_EN to make the accumulator saturate at
// 16'hFFFF. When it is undefined, the accumulator wraps modulo 2^16.
module ha_array_acc_seq #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] mul_x,
  output logic [7:0] mul_y,
  input  logic [6:0] ha_array_0_b,
  input  logic [8:0] ha_array_0_t,
  input  logic [6:0] ha_array_1_b,
  input  logic [8:0] ha_array_1_t,
  input  logic [6:0] ha_array_2_b,
  input  logic [8:0] ha_array_2_t,
  input  logic [6:0] ha_array_3_b,
  input  logic [8:0] ha_array_3_t,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [15:0] p,
  output logic       busy
);

  generate
    if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rows_per_cycle
      $error("ha_array_acc_seq: ROWS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // The last group of rows starts at row 4-ROWS_PER_CYCLE.
  // For ROWS_PER_CYCLE=4 this is row 0, which is the only group.
  localparam logic [1:0] LAST_BASE = 2'(4 - ROWS_PER_CYCLE);
  localparam logic [1:0] ROW_STEP  = 2'(ROWS_PER_CYCLE);

`ifdef HA_ACC_SAT_EN
  localparam int GW = 18;
`else
  localparam int GW = 16;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_mul_x;
  logic [7:0]  r_mul_y;
  logic [15:0] r_acc;
  logic [15:0] r_p;
  logic [1:0]  r_row;

  logic        w_accept;
  logic        w_acc_en;
  logic        w_last;

  logic [6:0]  w_b [4];
  logic [8:0]  w_t [4];
  logic [9:0]  w_row [4];
  logic [15:0] w_contrib [4];
  logic [GW-1:0] w_group;
  logic [15:0] w_acc_next;

  assign w_b[0] = ha_array_0_b;
  assign w_b[1] = ha_array_1_b;
  assign w_b[2] = ha_array_2_b;
  assign w_b[3] = ha_array_3_b;
  assign w_t[0] = ha_array_0_t;
  assign w_t[1] = ha_array_1_t;
  assign w_t[2] = ha_array_2_t;
  assign w_t[3] = ha_array_3_t;

  assign mul_x = r_mul_x;
  assign mul_y = r_mul_y;
  assign p     = r_p;

  // Weight each row and sum the group selected by the row counter.
  always_comb begin
    w_group = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_row[k]     = {1'b0, w_t[k]} + {1'b0, w_b[k], 2'b00};
      w_contrib[k] = {6'b0, w_row[k]} << (2 * k);
    end
    for (int unsigned j = 0; j < ROWS_PER_CYCLE; j++) begin
      w_group = w_group + GW'(w_contrib[r_row + 2'(j)]);
    end
  end

`ifdef HA_ACC_SAT_EN
  logic [17:0] w_sum;

  // Saturating add. Once the sum reaches 16'hFFFF it stays there, because every
  // row contribution is non-negative.
  always_comb begin
    w_sum      = {2'b00, r_acc} + w_group;
    w_acc_next = (|w_sum[17:16]) ? '1 : w_sum[15:0];
  end
`else
  // Wrapping add. The carry out of bit 15 is dropped.
  always_comb begin
    w_acc_next = r_acc + w_group;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic, handshake outputs and datapath strobes.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    w_accept  = 1'b0;
    w_acc_en  = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_ACC;
        end
      end
      S_ACC: begin
        w_acc_en = 1'b1;
        if (r_row == LAST_BASE) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers: operand latch, accumulator, row counter and product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_x <= '0;
      r_mul_y <= '0;
      r_acc   <= '0;
      r_row   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_mul_x <= x;
      r_mul_y <= y;
      r_acc   <= '0;
      r_row   <= '0;
    end else if (w_acc_en) begin
      r_acc <= w_acc_next;
      r_row <= r_row + ROW_STEP;
      if (w_last) begin
        r_p <= w_acc_next;
      end
    end
  end

endmodule

// File: tb/tb_ha_array_acc_seq.sv
// Directed bench for ha_array_acc_seq. Three instances run in lockstep, one for
// each legal ROWS_PER_CYCLE value (1, 2, 4), and share all inputs.
module tb_ha_array_acc_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] x;
  logic [7:0] y;
  logic [6:0] b0, b1, b2, b3;
  logic [8:0] t0, t1, t2, t3;
  logic       out_ready;

  logic [2:0] in_ready_v;
  logic [2:0] out_valid_v;
  logic [2:0] busy_v;
  logic [15:0] p_v [3];
  logic [7:0]  mx_v [3];
  logic [7:0]  my_v [3];

  int total;
  int bad;
  int lat [3];
  logic [7:0] mx_at1 [3];
  logic [7:0] my_at1 [3];
  int exp_lat [3] = '{5, 3, 2};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ha_array_acc_seq #(.ROWS_PER_CYCLE(1 << g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready_v[g]),
      .x            (x),
      .y            (y),
      .mul_x        (mx_v[g]),
      .mul_y        (my_v[g]),
      .ha_array_0_b (b0),
      .ha_array_0_t (t0),
      .ha_array_1_b (b1),
      .ha_array_1_t (t1),
      .ha_array_2_b (b2),
      .ha_array_2_t (t2),
      .ha_array_3_b (b3),
      .ha_array_3_t (t3),
      .out_valid    (out_valid_v[g]),
      .out_ready    (out_ready),
      .p            (p_v[g]),
      .busy         (busy_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_rows(input logic [6:0] vb0, input logic [8:0] vt0,
                          input logic [6:0] vb1, input logic [8:0] vt1,
                          input logic [6:0] vb2, input logic [8:0] vt2,
                          input logic [6:0] vb3, input logic [8:0] vt3);
    b0 = vb0; t0 = vt0; b1 = vb1; t1 = vt1;
    b2 = vb2; t2 = vt2; b3 = vb3; t3 = vt3;
  endtask

  // Present an operand pair that is accepted at the next rising edge.
  task automatic accept(input logic [7:0] xv, input logic [7:0] yv);
    @(negedge clk);
    x = xv;
    y = yv;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  // Count the negedges after acceptance until each out_valid goes high.
  // The search is bounded; a latency of 0 means the result never arrived.
  task automatic wait_valid;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
          mx_at1[i] = mx_v[i];
          my_at1[i] = my_v[i];
        end
      end
      for (int i = 0; i < 3; i++)
        if (out_valid_v[i] && lat[i] == 0) lat[i] = k;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready_v[i] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", i, in_ready_v[i]); end
      total++; if (out_valid_v[i] !== 1'b0) begin bad++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", i, out_valid_v[i]); end
      total++; if (busy_v[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy_v[i]); end
      total++; if (p_v[i] !== 16'h0000) begin bad++; $display("FAIL reset_p[%0d] got=%h exp=0000", i, p_v[i]); end
      total++; if (mx_v[i] !== 8'h00 || my_v[i] !== 8'h00) begin bad++; $display("FAIL reset_mul[%0d] got=%h/%h exp=00/00", i, mx_v[i], my_v[i]); end
    end
  endtask

  task automatic test_single;
    set_rows(7'h00, 9'h001, 7'h00, 9'h000, 7'h00, 9'h000, 7'h00, 9'h000);
    accept(8'h01, 8'h01);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      total++; if (lat[i] !== exp_lat[i]) begin bad++; $display("FAIL single_latency[%0d] got=%0d exp=%0d", i, lat[i], exp_lat[i]); end
      total++; if (mx_at1[i] !== 8'h01 || my_at1[i] !== 8'h01) begin bad++; $display("FAIL single_mul[%0d] got=%h/%h exp=01/01", i, mx_at1[i], my_at1[i]); end
      total++; if (p_v[i] !== 16'h0001) begin bad++; $display("FAIL single_p[%0d] got=%h exp=0001", i, p_v[i]); end
      total++; if (in_ready_v[i] !== 1'b0 || busy_v[i] !== 1'b1) begin bad++; $display("FAIL single_done_flags[%0d] got ready=%b busy=%b exp ready=0 busy=1", i, in_ready_v[i], busy_v[i]); end
    end
    release_out();
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid_v[i] !== 1'b0 || in_ready_v[i] !== 1'b1) begin bad++; $display("FAIL single_release[%0d] got valid=%b ready=%b exp valid=0 ready=1", i, out_valid_v[i], in_ready_v[i]); end
    end
  endtask

  task automatic test_row_weight;
    set_rows(7'h00, 9'h000, 7'h00, 9'h000, 7'h00, 9'h000, 7'h7F, 9'h1FF);
    accept(8'h12, 8'h34);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      total++; if (lat[i] !== exp_lat[i]) begin bad++; $display("FAIL row3_latency[%0d] got=%0d exp=%0d", i, lat[i], exp_lat[i]); end
      total++; if (p_v[i] !== 16'd65216) begin bad++; $display("FAIL row3_p[%0d] got=%0d exp=65216", i, p_v[i]); end
    end
    release_out();
  endtask

  task automatic test_overflow;
    logic [15:0] exp_p;
`ifdef HA_ACC_SAT_EN
    exp_p = 16'hFFFF;
`else
    exp_p = 16'd21079;
`endif
    set_rows(7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF);
    accept(8'hFF, 8'hFF);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      total++; if (p_v[i] !== exp_p) begin bad++; $display("FAIL overflow_p[%0d] got=%0d exp=%0d", i, p_v[i], exp_p); end
    end
    release_out();
  endtask

  task automatic test_backpressure;
    // Expected sum: row0 5+8=13, row1 (3+4)<<2=28, row2 16<<4=256, for 297 in total.
    set_rows(7'h02, 9'h005, 7'h01, 9'h003, 7'h00, 9'h010, 7'h00, 9'h000);
    accept(8'hA5, 8'h3C);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      total++; if (lat[i] !== exp_lat[i]) begin bad++; $display("FAIL bp_latency[%0d] got=%0d exp=%0d", i, lat[i], exp_lat[i]); end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      x = x + 8'h11;
      set_rows(7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF);
      for (int i = 0; i < 3; i++) begin
        total++; if (p_v[i] !== 16'd297) begin bad++; $display("FAIL bp_p_stable[%0d] cyc=%0d got=%0d exp=297", i, c, p_v[i]); end
        total++; if (in_ready_v[i] !== 1'b0 || out_valid_v[i] !== 1'b1) begin bad++; $display("FAIL bp_flags[%0d] cyc=%0d got ready=%b valid=%b exp ready=0 valid=1", i, c, in_ready_v[i], out_valid_v[i]); end
        total++; if (mx_v[i] !== 8'hA5 || my_v[i] !== 8'h3C) begin bad++; $display("FAIL bp_mul_hold[%0d] cyc=%0d got=%h/%h exp=a5/3c", i, c, mx_v[i], my_v[i]); end
      end
    end
    release_out();
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid_v[i] !== 1'b0 || in_ready_v[i] !== 1'b1) begin bad++; $display("FAIL bp_release[%0d] got valid=%b ready=%b exp valid=0 ready=1", i, out_valid_v[i], in_ready_v[i]); end
      total++; if (mx_v[i] !== 8'hA5 || my_v[i] !== 8'h3C) begin bad++; $display("FAIL bp_mul_after_idle[%0d] got=%h/%h exp=a5/3c", i, mx_v[i], my_v[i]); end
    end
  endtask

  task automatic test_back_to_back;
    set_rows(7'h00, 9'h000, 7'h00, 9'h002, 7'h00, 9'h000, 7'h00, 9'h000);
    accept(8'h55, 8'h66);
    wait_valid();
    release_out();
    // in_ready is already high here, so the next acceptance happens at the next edge.
    set_rows(7'h00, 9'h000, 7'h00, 9'h000, 7'h01, 9'h000, 7'h00, 9'h000);
    accept(8'h77, 8'h88);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      total++; if (lat[i] !== exp_lat[i]) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat[i], exp_lat[i]); end
      total++; if (p_v[i] !== 16'd64) begin bad++; $display("FAIL b2b_p[%0d] got=%0d exp=64", i, p_v[i]); end
      total++; if (mx_at1[i] !== 8'h77 || my_at1[i] !== 8'h88) begin bad++; $display("FAIL b2b_mul[%0d] got=%h/%h exp=77/88", i, mx_at1[i], my_at1[i]); end
    end
    release_out();
  endtask

  task automatic test_reset_mid_acc;
    logic seen;
    set_rows(7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF);
    accept(8'h9A, 8'hBC);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid_v[i] !== 1'b0 || in_ready_v[i] !== 1'b1) begin bad++; $display("FAIL midrst_flags[%0d] got valid=%b ready=%b exp valid=0 ready=1", i, out_valid_v[i], in_ready_v[i]); end
      total++; if (p_v[i] !== 16'h0000) begin bad++; $display("FAIL midrst_p[%0d] got=%h exp=0000", i, p_v[i]); end
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid_v != 3'b000) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_product got=%b exp=0", seen); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    set_rows('0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_row_weight();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_acc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ha_array_acc_seq.md
Name: ha_array_acc_seq

Overview:
- Sequencing controller for the 8x8 unsigned approximate multiplier's half-adder compression stage.
- Accepts operand pairs over a valid/ready handshake and holds them on the datapath operand lines.
- Folds the four ha_array row outputs (b/t pairs) into one 16-bit product with a shared time-multiplexed adder, then presents the result over a valid/ready handshake.
- Sits between the operand source and the final-product consumer; the compression stage stays combinational and external.

Parameters:
ROWS_PER_CYCLE, 1, rows accumulated per cycle; legal values 1, 2, 4; any other value is a elaboration error.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept an operand pair.
x  input  8  multiplicand.
y  input  8  multiplier.
mul_x  output  8  registered operand driven to the compression datapath.
mul_y  output  8  registered operand driven to the compression datapath.
ha_array_k_b  input  7  row k carry vector from the datapath; k = 0..3, one port per row.
ha_array_k_t  input  9  row k sum vector from the datapath; k = 0..3, one port per row.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts the product.
p  output  16  accumulated product.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, mul_x=0, mul_y=0, accumulator=0, row counter=0. Reset asserted mid-operation aborts the operation immediately; the in-flight result is discarded and never presented.
- Row value: R_k = ha_array_k_t + (ha_array_k_b << 2), 10 bits zero-extended. Contribution = R_k << (2*k).
- Accumulation is modulo 2^16 by default; the carry out of bit 15 is dropped.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch x into mul_x and y into mul_y, clear the accumulator, set row counter=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each cycle, add the contributions of rows counter..counter+ROWS_PER_CYCLE-1 (sampled from the combinational datapath) into the accumulator.
  - Advance the counter by ROWS_PER_CYCLE.
  - After row 3 is added, go to DONE. ACC lasts 4/ROWS_PER_CYCLE cycles.
- DONE:
  - out_valid=1; p holds the final accumulator, stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - in_ready stays 0 in DONE; there is no overlap with the next operand.
- Latency: from the handshake cycle to out_valid high is 4/ROWS_PER_CYCLE+1 cycles (5, 3 or 2).
- Back-to-back: the earliest next in_valid acceptance is the cycle after the out handshake.
- mul_x and mul_y hold their value from acceptance until the next acceptance. They are unaffected by DONE->IDLE.
- Changes on x/y/in_valid outside an IDLE handshake are ignored.
- Datapath inputs are sampled only in ACC; glitches in other states have no effect.

Optional Feature:
- Macro HA_ACC_SAT_EN.
- Defined: the accumulator saturates. Any addition whose true sum exceeds 16'hFFFF yields 16'hFFFF, and the accumulator stays 16'hFFFF for the remaining rows.
- Undefined: modulo-2^16 wrap as in Behaviour.
- Reset and handshake behaviour are identical in both builds.

Test Plan:
- Reset mid-ACC (ROWS_PER_CYCLE=1: assert rst 2 cycles after acceptance) -> out_valid=0, p=0, in_ready=1 immediately after reset; no product is ever presented for the aborted operation.
- ROWS_PER_CYCLE=1: x=8'h01, y=8'h01 with datapath stub row0 t=9'h001, all other vectors 0 -> out_valid rises 5 cycles after acceptance; p=16'h0001; mul_x=8'h01 and mul_y=8'h01 from the cycle after acceptance.
- Row weighting: only row 3 driven, t=9'h1FF, b=7'h7F -> R_3=1019, p=16'd65216; repeat with ROWS_PER_CYCLE=2 and 4 -> same p, latency 3 and 2 respectively.
- Overflow: all rows t=9'h1FF, b=7'h7F (sum 86615) -> p=16'd21079 without HA_ACC_SAT_EN; p=16'hFFFF with HA_ACC_SAT_EN.
- Backpressure: hold out_ready=0 for 6 cycles in DONE, toggle in_valid and x -> p stable, in_ready=0, no new acceptance; out_ready=1 -> out_valid low next cycle, in_ready=1.
